// File: rtl/calc_if.sv
// Keypad-to-display bus for calc_engine: key events in, BCD display and status out.
interface calc_if;
   logic [3:0] digit;
   logic       keystrobe;
   logic       bksp;
   logic [3:0] bcd1;
   logic [3:0] bcd10;
   logic [3:0] bcd100;
   logic       neg;
   logic       err;
   logic       busy;

   modport master (
      output digit, keystrobe, bksp,
      input  bcd1, bcd10, bcd100, neg, err, busy
   );

   modport slave (
      input  digit, keystrobe, bksp,
      output bcd1, bcd10, bcd100, neg, err, busy
   );
endinterface

// File: rtl/calc_engine.sv
// Three-digit add/subtract calculator with a sequential double-dabble result converter.
// Optional backspace key enabled by defining CALC_BKSP_EN.
// The display register doubles as the BCD entry buffer while an operand is typed.
module calc_engine (
   input logic   clock,
   input logic   reset_n,
   calc_if.slave bus
);
   localparam int unsigned DIG_W = 4;
   localparam int unsigned BCD_W = 12;
   localparam int unsigned MAG_W = 10;
   localparam int unsigned RES_W = 11;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned DD_W  = BCD_W + MAG_W;
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(10);

   typedef enum logic [2:0] {ENTER_A, ENTER_B, CONVERT, SHOW, ERROR} state_t;

   state_t             state, state_nx;
   logic [BCD_W-1:0]   disp, disp_nx;
   logic [BCD_W-1:0]   op_a, op_a_nx;
   logic               is_sub, is_sub_nx;
   logic               neg, neg_nx;
   logic               err, err_nx;
   logic [RES_W-1:0]   res, res_nx;
   logic [DD_W-1:0]    dd, dd_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;

   logic               key_ok, k_digit, k_op, k_clr, k_eq, k_bk;
   logic [MAG_W-1:0]   a_bin, b_bin, mag;
   logic               ovf, conv_done;

   function automatic logic [MAG_W-1:0] bcd2bin(input logic [BCD_W-1:0] b);
      return MAG_W'(b[11:8]) * MAG_W'(100) + MAG_W'(b[7:4]) * MAG_W'(10) + MAG_W'(b[3:0]);
   endfunction

   // One double-dabble round: add 3 to every BCD digit >= 5, then shift left.
   function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
      logic [DD_W-1:0] t;
      t = v;
      for (int i = 0; i < 3; i++) begin
         if (t[MAG_W + 4*i +: DIG_W] >= 4'd5)
            t[MAG_W + 4*i +: DIG_W] = t[MAG_W + 4*i +: DIG_W] + 4'd3;
      end
      return DD_W'({t, 1'b0});
   endfunction

   // Key decode; every event is dropped while converting.
   assign key_ok  = bus.keystrobe && (state != CONVERT);
   assign k_digit = key_ok && (bus.digit <= 4'd9);
   assign k_op    = key_ok && ((bus.digit == 4'hA) || (bus.digit == 4'hB));
   assign k_clr   = key_ok && (bus.digit == 4'hC);
   assign k_eq    = key_ok && (bus.digit == 4'hD);
`ifdef CALC_BKSP_EN
   assign k_bk    = bus.bksp && !bus.keystrobe && (state != CONVERT);
`else
   logic unused_bksp;
   assign unused_bksp = bus.bksp;
   assign k_bk    = 1'b0;
`endif

   assign a_bin     = bcd2bin(op_a);
   assign b_bin     = bcd2bin(disp);
   assign mag       = MAG_W'((is_sub && res[RES_W-1]) ? -res : res);
   assign ovf       = !is_sub && (res > RES_W'(999));
   assign conv_done = (state == CONVERT) && (cnt == LAST_SHIFT);

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) state <= ENTER_A;
      else          state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         ENTER_A: if (k_op) state_nx = ENTER_B;
         ENTER_B: begin
            if (k_clr)     state_nx = ENTER_A;
            else if (k_eq) state_nx = CONVERT;
         end
         CONVERT: if (conv_done) state_nx = ovf ? ERROR : SHOW;
         SHOW: begin
            if (k_clr || k_digit)  state_nx = ENTER_A;
            else if (k_op && !neg) state_nx = ENTER_B;
         end
         ERROR:   if (k_clr) state_nx = ENTER_A;
         default: state_nx = ENTER_A;
      endcase
   end

   // Datapath next values: entry editing, operand latch, compute and conversion.
   always_comb begin
      disp_nx   = disp;
      op_a_nx   = op_a;
      is_sub_nx = is_sub;
      neg_nx    = neg;
      err_nx    = err;
      res_nx    = res;
      dd_nx     = dd;
      cnt_nx    = cnt;
      if (k_clr) begin
         disp_nx   = '0;
         op_a_nx   = '0;
         is_sub_nx = 1'b0;
         neg_nx    = 1'b0;
         err_nx    = 1'b0;
      end else begin
         case (state)
            ENTER_A, ENTER_B: begin
               if (k_digit && (disp[11:8] == 4'd0)) begin
                  disp_nx = {disp[7:0], bus.digit};
               end else if (k_bk) begin
                  disp_nx = {4'd0, disp[11:4]};
               end else if (k_op && (state == ENTER_A)) begin
                  op_a_nx   = disp;
                  is_sub_nx = (bus.digit == 4'hB);
                  disp_nx   = '0;
               end else if (k_eq && (state == ENTER_B)) begin
                  res_nx = is_sub ? (RES_W'(a_bin) - RES_W'(b_bin))
                                  : (RES_W'(a_bin) + RES_W'(b_bin));
                  cnt_nx = '0;
               end
            end
            CONVERT: begin
               cnt_nx = cnt + CNT_W'(1);
               if (cnt == '0) dd_nx = {{BCD_W{1'b0}}, mag};
               else           dd_nx = dd_step(dd);
               if (conv_done) begin
                  if (ovf) begin
                     err_nx  = 1'b1;
                     disp_nx = '0;
                     neg_nx  = 1'b0;
                  end else begin
                     disp_nx = dd_nx[DD_W-1:MAG_W];
                     neg_nx  = is_sub && res[RES_W-1];
                  end
               end
            end
            SHOW: begin
               if (k_digit) begin
                  disp_nx = {8'd0, bus.digit};
                  neg_nx  = 1'b0;
               end else if (k_op && !neg) begin
                  op_a_nx   = disp;
                  is_sub_nx = (bus.digit == 4'hB);
                  disp_nx   = '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         disp   <= '0;
         op_a   <= '0;
         is_sub <= 1'b0;
         neg    <= 1'b0;
         err    <= 1'b0;
         res    <= '0;
         dd     <= '0;
         cnt    <= '0;
      end else begin
         disp   <= disp_nx;
         op_a   <= op_a_nx;
         is_sub <= is_sub_nx;
         neg    <= neg_nx;
         err    <= err_nx;
         res    <= res_nx;
         dd     <= dd_nx;
         cnt    <= cnt_nx;
      end
   end

   assign bus.bcd1   = disp[3:0];
   assign bus.bcd10  = disp[7:4];
   assign bus.bcd100 = disp[11:8];
   assign bus.neg    = neg;
   assign bus.err    = err;
   assign bus.busy   = (state == CONVERT);
endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine: key-sequence table, corner sequences, random keys vs model.
module tb_calc_engine;
`ifdef CALC_BKSP_EN
   localparam bit BKSP_EN = 1'b1;
`else
   localparam bit BKSP_EN = 1'b0;
`endif
   localparam int ST_A = 0, ST_B = 1, ST_SHOW = 2, ST_ERR = 3;
   localparam int NV = 11;

   logic clock;
   logic reset_n;
   calc_if bus ();

   calc_engine u_dut (.clock(clock), .reset_n(reset_n), .bus(bus));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model in plain integers: displayed value, operands, remaining busy cycles.
   int m_st, m_disp, m_a, m_res, m_busy;
   bit m_sub, m_neg, m_err;

   typedef struct packed {
      logic [31:0] keys;
      logic [3:0]  n;
      logic [11:0] bcd;
      logic        neg;
      logic        err;
      logic [4:0]  nbusy;
   } vec_t;

   vec_t vec [NV];

   function automatic logic [14:0] act_vec();
      return {bus.bcd100, bus.bcd10, bus.bcd1, bus.neg, bus.err, bus.busy};
   endfunction

   function automatic logic [14:0] model_vec();
      return {4'(m_disp / 100), 4'((m_disp / 10) % 10), 4'(m_disp % 10), m_neg, m_err, m_busy > 0};
   endfunction

   task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got bcd=%h neg=%b err=%b busy=%b, expected bcd=%h neg=%b err=%b busy=%b",
                  name, act[14:3], act[2], act[1], act[0], exp[14:3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic m_clear();
      m_st = ST_A; m_disp = 0; m_a = 0; m_sub = 0; m_neg = 0; m_err = 0;
   endtask

   task automatic model_step(input bit ks, input logic [3:0] d, input bit bk, input bit rs);
      if (!rs) begin
         m_clear();
         m_busy = 0;
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            if (!m_sub && m_res > 999) begin
               m_st = ST_ERR; m_err = 1; m_disp = 0; m_neg = 0;
            end else begin
               m_st = ST_SHOW; m_neg = (m_res < 0); m_disp = (m_res < 0) ? -m_res : m_res;
            end
         end
      end else if (ks) begin
         if (d <= 4'd9) begin
            if (m_st == ST_A || m_st == ST_B) begin
               if (m_disp < 100) m_disp = m_disp * 10 + int'(d);
            end else if (m_st == ST_SHOW) begin
               m_st = ST_A; m_disp = int'(d); m_neg = 0;
            end
         end else if (d == 4'hA || d == 4'hB) begin
            if (m_st == ST_A || (m_st == ST_SHOW && !m_neg)) begin
               m_a = m_disp; m_sub = (d == 4'hB); m_disp = 0; m_st = ST_B;
            end
         end else if (d == 4'hC) begin
            m_clear();
         end else if (d == 4'hD) begin
            if (m_st == ST_B) begin
               m_res = m_sub ? m_a - m_disp : m_a + m_disp;
               m_busy = 11;
            end
         end
      end else if (bk && BKSP_EN) begin
         if (m_st == ST_A || m_st == ST_B) m_disp = m_disp / 10;
      end
   endtask

   // One clock: drive at the falling edge, advance model at the rising edge, check at the next falling edge.
   task automatic tick(input bit ks, input logic [3:0] d, input bit bk, input bit rs);
      bus.keystrobe = ks; bus.digit = d; bus.bksp = bk; reset_n = rs;
      @(posedge clock);
      model_step(ks, d, bk, rs);
      @(negedge clock);
      chk("cycle", act_vec(), model_vec());
   endtask

   task automatic press(input logic [3:0] k);
      tick(1'b1, k, 1'b0, 1'b1);
   endtask

   task automatic idle();
      tick(1'b0, 4'h0, 1'b0, 1'b1);
   endtask

   // Count busy samples until busy drops; bounded.
   task automatic wait_idle(output int nb);
      nb = 0;
      for (int i = 0; i < 20; i++) begin
         if (!bus.busy) break;
         nb++;
         idle();
      end
      if (bus.busy) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: busy still 1 after 20 cycles, expected 0");
      end
   endtask

   initial begin
      int nb;
      logic [31:0] keys;
      bit ks, bk, rs;
      logic [3:0] d;
      int r;

      vec[0]  = '{keys: 32'h1234_0000, n: 4'd4, bcd: 12'h123, neg: 1'b0, err: 1'b0, nbusy: 5'd0};
      vec[1]  = '{keys: 32'h123A_456D, n: 4'd8, bcd: 12'h579, neg: 1'b0, err: 1'b0, nbusy: 5'd11};
      vec[2]  = '{keys: 32'h45B1_20D0, n: 4'd7, bcd: 12'h075, neg: 1'b1, err: 1'b0, nbusy: 5'd11};
      vec[3]  = '{keys: 32'h999A_1D00, n: 4'd6, bcd: 12'h000, neg: 1'b0, err: 1'b1, nbusy: 5'd11};
      vec[4]  = '{keys: 32'h5B5D_0000, n: 4'd4, bcd: 12'h000, neg: 1'b0, err: 1'b0, nbusy: 5'd11};
      vec[5]  = '{keys: 32'h999A_999D, n: 4'd8, bcd: 12'h000, neg: 1'b0, err: 1'b1, nbusy: 5'd11};
      vec[6]  = '{keys: 32'h0B99_9D00, n: 4'd6, bcd: 12'h999, neg: 1'b1, err: 1'b0, nbusy: 5'd11};
      vec[7]  = '{keys: 32'h2A3A_4D00, n: 4'd6, bcd: 12'h036, neg: 1'b0, err: 1'b0, nbusy: 5'd11};
      vec[8]  = '{keys: 32'h5DA1_D000, n: 4'd5, bcd: 12'h006, neg: 1'b0, err: 1'b0, nbusy: 5'd11};
      vec[9]  = '{keys: 32'h500A_499D, n: 4'd8, bcd: 12'h999, neg: 1'b0, err: 1'b0, nbusy: 5'd11};
      vec[10] = '{keys: 32'h0001_2000, n: 4'd5, bcd: 12'h012, neg: 1'b0, err: 1'b0, nbusy: 5'd0};

      bus.digit = 4'h0; bus.keystrobe = 1'b0; bus.bksp = 1'b0; reset_n = 1'b0;
      m_clear();
      m_busy = 0; m_res = 0;
      @(negedge clock);
      tick(1'b0, 4'h0, 1'b0, 1'b0);
      tick(1'b0, 4'h0, 1'b0, 1'b0);
      chk("reset", act_vec(), 15'h0);

      // Table of key sequences, each from a cleared calculator.
      for (int v = 0; v < NV; v++) begin
         press(4'hC);
         keys = vec[v].keys;
         for (int k = 0; k < int'(vec[v].n); k++) press(keys[31-4*k -: 4]);
         wait_idle(nb);
         checks++;
         if (nb != int'(vec[v].nbusy)) begin
            errors++;
            $display("FAIL vec%0d busy_len: got %0d expected %0d", v, nb, vec[v].nbusy);
         end
         chk($sformatf("vec%0d", v), act_vec(), {vec[v].bcd, vec[v].neg, vec[v].err, 1'b0});
      end

      // Negative result: A and B are ignored, a digit starts a fresh entry.
      press(4'hC); press(4'h4); press(4'h5); press(4'hB); press(4'h1); press(4'h2); press(4'h0); press(4'hD);
      wait_idle(nb);
      press(4'hA);
      chk("neg_op_ignored", act_vec(), {12'h075, 1'b1, 1'b0, 1'b0});
      press(4'h3);
      chk("show_digit", act_vec(), {12'h003, 1'b0, 1'b0, 1'b0});

      // Overflow error: only C leaves it.
      press(4'hC); press(4'h9); press(4'h9); press(4'h9); press(4'hA); press(4'h1); press(4'hD);
      wait_idle(nb);
      press(4'h5);
      chk("err_digit_ignored", act_vec(), {12'h000, 1'b0, 1'b1, 1'b0});
      press(4'hC);
      chk("err_clear", act_vec(), 15'h0);

      // Chained operation from a positive result.
      press(4'hC); press(4'h1); press(4'h2); press(4'h3); press(4'hA); press(4'h4); press(4'h5); press(4'h6); press(4'hD);
      wait_idle(nb);
      press(4'hB); press(4'h9); press(4'hD);
      wait_idle(nb);
      chk("chain", act_vec(), {12'h570, 1'b0, 1'b0, 1'b0});

      // Backspace, and keystrobe winning over a simultaneous backspace.
      press(4'hC); press(4'h1); press(4'h2); press(4'h3);
      tick(1'b0, 4'h0, 1'b1, 1'b1);
      chk("bksp", act_vec(), {(BKSP_EN ? 12'h012 : 12'h123), 3'b000});
      press(4'hC); press(4'h1); press(4'h2);
      tick(1'b1, 4'h7, 1'b1, 1'b1);
      chk("bksp_with_key", act_vec(), {12'h127, 3'b000});

      // C during conversion is dropped.
      press(4'hC); press(4'h1); press(4'hA); press(4'h2); press(4'hD);
      press(4'hC);
      chk("clr_while_busy", act_vec(), {12'h002, 3'b001});
      wait_idle(nb);
      chk("clr_while_busy_result", act_vec(), {12'h003, 3'b000});

      // Reset on the 5th busy cycle aborts the conversion.
      press(4'hC); press(4'h1); press(4'hA); press(4'h2); press(4'hD);
      for (int i = 0; i < 4; i++) idle();
      tick(1'b0, 4'h0, 1'b0, 1'b0);
      chk("reset_mid_convert", act_vec(), 15'h0);
      for (int i = 0; i < 15; i++) begin
         idle();
         chk("no_late_result", act_vec(), 15'h0);
      end

      // Random key traffic against the model.
      for (int i = 0; i < 600; i++) begin
         r  = int'($urandom_range(0, 199));
         ks = ($urandom_range(0, 99) < 45);
         d  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) d = 4'hD;
         bk = ($urandom_range(0, 9) < 2);
         rs = (r != 0);
         tick(ks, d, bk, rs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/calc_engine.md
CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port digit  input  4  keycode from the debounced keypad stage; sampled only when keystrobe=1.
REQ-004 SHALL have port keystrobe  input  1  one-cycle key-event pulse.
REQ-005 SHALL have port bksp  input  1  one-cycle backspace pulse; used only when CALC_BKSP_EN is defined.
REQ-006 SHALL have ports bcd1, bcd10, bcd100  output  4 each  displayed value as ones/tens/hundreds BCD digits, feeding char_7seg.
REQ-007 SHALL have port neg  output  1  displayed result is negative (magnitude on the bcd outputs).
REQ-008 SHALL have port err  output  1  overflow error latched.
REQ-009 SHALL have port busy  output  1  conversion in progress; key events are dropped while high.

Function
REQ-010 SHALL decode digit as: 0-9 digit, A add, B subtract, C clear, D equals; E and F ignored.
REQ-011 SHALL implement the states ENTER_A, ENTER_B, CONVERT, SHOW and ERROR.
REQ-012 SHALL, in ENTER_A or ENTER_B on a digit key, set entry = entry*10 + digit when entry < 100 and ignore the key otherwise (3-digit limit, 0-999).
REQ-013 SHALL drive every output from registers, with bcd outputs reflecting a key event on the cycle after its strobe.
REQ-014 SHALL, in ENTER_A and ENTER_B, display the current entry with neg=0.
REQ-015 SHALL, on A or B in ENTER_A, latch operand A and the operator, clear the entry to 0, and go to ENTER_B.
REQ-016 SHALL ignore A and B in ENTER_B (no chaining).
REQ-017 SHALL ignore D in ENTER_A.
REQ-018 SHALL, on D in ENTER_B, compute A+B or A-B as an 11-bit signed value, go to CONVERT, and assert busy from the next cycle for exactly 11 cycles (1 compute cycle + 10 sequential double-dabble shifts).
REQ-019 SHALL, at the end of CONVERT, present the magnitude on the bcd outputs with neg=1 iff A-B<0, deassert busy, and go to SHOW.
REQ-020 SHALL, when an add result exceeds 999, go to ERROR instead of SHOW with err=1, bcd outputs 0, neg=0 and busy=0 on the same cycle.
REQ-021 SHALL, in SHOW on a digit key, start a new entry in ENTER_A with that digit and clear neg.
REQ-022 SHALL, in SHOW on A or B with neg=0, use the result as operand A and go to ENTER_B; with neg=1 the key SHALL be ignored.
REQ-023 SHALL, on C in any state except CONVERT, go to ENTER_A with entry, operands, neg and err all cleared.
REQ-024 SHALL, in ERROR, ignore every key except C.
REQ-025 SHALL drop all keystrobe and bksp events while busy=1, including C.
REQ-026 SHALL, when keystrobe and bksp are both high in the same cycle, process keystrobe and drop bksp.

Reset
REQ-027 SHALL, on a clock edge with reset_n=0, enter ENTER_A with bcd1=bcd10=bcd100=0, neg=0, err=0, busy=0 and operands cleared.
REQ-028 SHALL apply reset from any state, including mid-CONVERT, and abort the conversion with no later result appearing.

Configuration
REQ-029 SHALL, with macro CALC_BKSP_EN defined, on bksp in ENTER_A or ENTER_B, set entry = entry/10 (BCD shift right; 0 stays 0) and ignore bksp in all other states.
REQ-030 SHALL, without CALC_BKSP_EN, keep the bksp port but ignore it entirely and synthesise no backspace logic.

Verification
REQ-031 SHALL cover: reset, keys 1,2,3,4 -> bcd100/10/1 = 1/2/3; the 4th key has no effect.
REQ-032 SHALL cover: 1,2,3,A,4,5,6,D -> busy high 11 cycles, then 5/7/9 with neg=0 and err=0.
REQ-033 SHALL cover: 4,5,B,1,2,0,D -> 0/7/5 with neg=1; then A -> ignored, state stays SHOW.
REQ-034 SHALL cover: 9,9,9,A,1,D -> err=1 and 0/0/0; then digit 5 -> ignored; then C -> err=0 in ENTER_A.
REQ-035 SHALL cover: 1,2,3 then bksp -> 0/1/2 with CALC_BKSP_EN; 1/2/3 unchanged without it; bksp in the same cycle as key 7 -> 7 is taken and bksp dropped.
REQ-036 SHALL cover: reset_n=0 on the 5th busy cycle -> next cycle all outputs 0 and busy=0; no result appears afterwards.
